// File: rtl/mom_bank_seq_pkg.sv
// Shared types, defaults and helpers for the mom_bank_seq capacitor-bank sequencer.
package mom_bank_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_SEG_DEF      = 16;
  localparam int STEP_W_DEF     = 8;
  localparam int SETTLE_CYC_DEF = 4;
  // Widest bank therm() can describe; callers size-cast down to their N_SEG.
  localparam int MAX_SEG        = 64;

  function automatic int code_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [MAX_SEG-1:0] therm(input int code);
    logic [MAX_SEG-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_SEG; i++) v[i] = (i < code);
    return v;
  endfunction

endpackage

// File: rtl/mom_bank_seq_if.sv
// Request channel from the rail-control register block to mom_bank_seq.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// the master holds req_valid, req_code and step_div stable until that edge, and
// req_ready never depends combinationally on req_valid.
interface mom_bank_seq_if #(
  parameter int CODE_W = 5,
  parameter int STEP_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [CODE_W-1:0] req_code;
  logic [STEP_W-1:0] step_div;

  modport master (output req_valid, output req_code, output step_div, input req_ready);
  modport slave  (input req_valid, input req_code, input step_div, output req_ready);
endinterface

// File: rtl/mom_seq_timer.sv
// Loadable down-counter with zero flag; shared by the step interval and the settle count.
module mom_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mom_bank_seq.sv
// Ramps a thermometer-coded MOM/decap segment bank one segment per step toward a target.
// Optional abort input/aborted output are built when MOM_BANK_SEQ_ABORT_EN is defined.
module mom_bank_seq
  import mom_bank_seq_pkg::*;
#(
  parameter int N_SEG      = N_SEG_DEF,
  parameter int CODE_W     = code_w(N_SEG),
  parameter int STEP_W     = STEP_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mom_bank_seq_if.slave     req,
  output logic [N_SEG-1:0]  seg_en,
  output logic [CODE_W-1:0] cur_code,
  output logic              busy,
  output logic              done,
  output logic              range_err,
`ifdef MOM_BANK_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output state_t            dbg_state
);

  localparam logic [CODE_W-1:0] N_SEG_C = CODE_W'(N_SEG);

  state_t            state, state_nxt;
  logic [CODE_W-1:0] target;
  logic [STEP_W-1:0] div;
  logic [CODE_W-1:0] tgt_in, code_step;
  logic [STEP_W-1:0] div_in;
  logic              accept, step;
  logic              t_load, t_dec, t_zero;
  logic [STEP_W-1:0] t_val;
`ifdef MOM_BANK_SEQ_ABORT_EN
  logic              abort_hit;
`endif

  assign tgt_in    = (req.req_code > N_SEG_C) ? N_SEG_C : req.req_code;
  assign div_in    = (req.step_div == '0) ? STEP_W'(1) : req.step_div;
  assign code_step = (target > cur_code) ? cur_code + 1'b1 : cur_code - 1'b1;

  mom_seq_timer #(.W(STEP_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    t_load    = 1'b0;
    t_dec     = 1'b0;
    t_val     = '0;
`ifdef MOM_BANK_SEQ_ABORT_EN
    abort_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req.req_valid) begin
          accept    = 1'b1;
          t_load    = 1'b1;
          state_nxt = (tgt_in == cur_code) ? DONE : RAMP;
        end
      end
      RAMP: begin
`ifdef MOM_BANK_SEQ_ABORT_EN
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = DONE;
        end else
`endif
        if (t_zero) begin
          step   = 1'b1;
          t_load = 1'b1;
          if (code_step == target) begin
            t_val     = STEP_W'(SETTLE_CYC);
            state_nxt = SETTLE;
          end else begin
            t_val = div - 1'b1;
          end
        end else begin
          t_dec = 1'b1;
        end
      end
      SETTLE: begin
`ifdef MOM_BANK_SEQ_ABORT_EN
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = DONE;
        end else
`endif
        if (t_zero) state_nxt = DONE;
        else        t_dec     = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Segment enables only ever move to the neighbouring thermometer code.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_en    <= '0;
      cur_code  <= '0;
      target    <= '0;
      div       <= STEP_W'(1);
      range_err <= 1'b0;
    end else begin
      range_err <= 1'b0;
      if (accept) begin
        target    <= tgt_in;
        div       <= div_in;
        range_err <= (req.req_code > N_SEG_C);
      end
      if (step) begin
        cur_code <= code_step;
        seg_en   <= N_SEG'(therm(int'(code_step)));
      end
    end
  end

`ifdef MOM_BANK_SEQ_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) aborted <= 1'b0;
    else     aborted <= abort_hit;
  end
`endif

  assign req.req_ready = (state == IDLE);
  assign busy          = (state == RAMP) || (state == SETTLE);
  assign done          = (state == DONE);
  assign dbg_state     = state;

endmodule

// File: doc/mom_bank_seq.md
Name: mom_bank_seq

Overview:
- Sequencer for a bank of N_SEG switchable MOM/decap capacitor segments on one rail.
- Ramps the number of enabled segments toward a requested target code, one segment per programmable step interval, so supply droop and inrush stay bounded.
- Waits a fixed settle time after the last step, then signals completion.
- Sits between the rail-control register block (requester) and the segment switch drivers in the analog macro.

Parameters:
- N_SEG, 16, number of capacitor segments; SEG_EN width.
- CODE_W, $clog2(N_SEG+1), width of segment-count codes.
- STEP_W, 8, width of the STEP_DIV step-interval input.
- SETTLE_CYC, 4, cycles held in SETTLE after the final step (0 allowed).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  block can accept a request.
- REQ_CODE  in  CODE_W  target number of enabled segments.
- STEP_DIV  in  STEP_W  cycles between segment steps; 0 is treated as 1; sampled at accept.
- SEG_EN  out  N_SEG  thermometer enable, bit 0 filled first.
- CUR_CODE  out  CODE_W  popcount of SEG_EN.
- BUSY  out  1  high in RAMP and SETTLE.
- DONE  out  1  one-cycle completion pulse.
- RANGE_ERR  out  1  one-cycle pulse: REQ_CODE exceeded N_SEG at accept.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state IDLE, SEG_EN=0, CUR_CODE=0, BUSY=0, DONE=0, RANGE_ERR=0, REQ_READY=1. RST asserted mid-ramp clears SEG_EN at that edge and discards the request.
- States: IDLE, RAMP, SETTLE, DONE.
- Handshake: REQ_READY=1 only in IDLE. A request is accepted on an edge with REQ_VALID&&REQ_READY. At accept the block latches the target (clamped to N_SEG) and div=max(STEP_DIV,1).
- Range check: if REQ_CODE>N_SEG, the target is clamped to N_SEG and RANGE_ERR pulses in the cycle after accept.
- Accept transitions: target==CUR_CODE goes IDLE->DONE (no settle). Otherwise IDLE->RAMP with timer=0.
- RAMP, timer==0: add one segment (bit CUR_CODE set) if target>CUR, else remove the top segment (bit CUR-1 cleared). Then timer<=div-1. If the new code equals target, go to SETTLE with cnt=SETTLE_CYC.
- RAMP, timer!=0: timer decrements.
- SEG_EN changes by exactly one bit per step and never skips or glitches.
- Step timing: the first step occurs at the edge after accept. Later steps occur every div cycles.
- SETTLE: if cnt==0 go to DONE, else cnt decrements.
- DONE: DONE=1 for exactly one cycle, REQ_READY=0, next state IDLE. A new request can be accepted in the following cycle.
- Step counter: the timer is STEP_W bits and div-1 never underflows.
- Outputs: all outputs are registered. CUR_CODE always equals popcount(SEG_EN).

Optional Feature:
- Macro: MOM_BANK_SEQ_ABORT_EN.
- With the macro: extra input ABORT (1 bit). ABORT=1 in RAMP or SETTLE freezes SEG_EN at its current value and moves to DONE on that edge. The following DONE pulse is accompanied by extra output ABORTED=1 (same cycle). ABORT is ignored in IDLE and DONE.
- Without the macro: neither port exists and every accepted request runs to completion.

Decomposition:
- Package mom_bank_seq_pkg holds:
  - state enum (IDLE, RAMP, SETTLE, DONE);
  - default constants for N_SEG/STEP_W/SETTLE_CYC;
  - function code_w(n)=$clog2(n+1);
  - function therm(code) returning an N_SEG thermometer vector.
- One sub-module, mom_seq_timer: loadable down-counter with zero flag, reused for the step interval and the settle count.

Test Plan:
- Reset with RST=1 for 2 cycles -> SEG_EN=0, CUR_CODE=0, REQ_READY=1, BUSY=0, DONE=0.
- Up-ramp from 0: REQ_CODE=3, STEP_DIV=2, SETTLE_CYC=4, accept at edge 0:
  - SEG_EN=0x1/0x3/0x7 after edges 1/3/5;
  - DONE high only after edge 10;
  - REQ_READY back high after edge 11.
- Down-ramp from 7 to 5 with STEP_DIV=0 (treated as 1) -> SEG_EN 0x7F->0x3F->0x1F on consecutive edges, then settle, then DONE.
- Same-code request (REQ_CODE=CUR_CODE=5) -> DONE pulse after edge 1, SEG_EN unchanged, BUSY never high.
- Clamp with N_SEG=16: REQ_CODE=20 -> RANGE_ERR pulse after edge 1, final SEG_EN=0xFFFF.
- Reset mid-ramp (RST at code 2 of a ramp to 6) -> SEG_EN=0 next cycle, REQ_READY=1, no DONE pulse. With MOM_BANK_SEQ_ABORT_EN: ABORT at code 4 -> SEG_EN=0xF frozen, DONE and ABORTED together.
